ecc_scalar_mult_ctrl: RTL

- Upstream sequencer for the point-add-always unit and the point-doubling unit. Computes R = k·P using MSB-first double-and-add-always.
- After the leading 1 of k, every scalar bit costs exactly one doubling plus one add request. The add request carries the scalar bit as the add/dummy select.
- Sits between the top-level ECC command logic and the two point-arithmetic units. It owns the accumulator point and the scalar shift register.

---
 rtl/ecc_scalar_mult_ctrl_if.sv | 53 +++++
 rtl/ecc_scalar_mult_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ecc_scalar_mult_ctrl_if.sv
// Bundle between the ECC command logic, the scalar-multiply sequencer and the
// point-doubling / point-add-always units.
//   i_start/i_k/i_px/i_py           : command from the ECC top level
//   o_busy/o_done/o_rx/o_ry         : status and result back to the top level
//   o_dbl_* / i_dbl_*               : request/response with the doubling unit
//   o_add_* / i_add_*               : request/response with the add unit
// The master modport is the environment around the sequencer.
// The slave modport is the sequencer itself.
interface ecc_scalar_mult_ctrl_if #(
  parameter int unsigned WIDTH = 256
);
  logic             i_start;
  logic [WIDTH-1:0] i_k;
  logic [WIDTH-1:0] i_px;
  logic [WIDTH-1:0] i_py;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_rx;
  logic [WIDTH-1:0] o_ry;
  logic             o_dbl_start;
  logic [WIDTH-1:0] o_dbl_x;
  logic [WIDTH-1:0] o_dbl_y;
  logic             i_dbl_finish;
  logic [WIDTH-1:0] i_dbl_x;
  logic [WIDTH-1:0] i_dbl_y;
  logic             o_add_start;
  logic [WIDTH-1:0] o_add_x1;
  logic [WIDTH-1:0] o_add_y1;
  logic [WIDTH-1:0] o_add_x2;
  logic [WIDTH-1:0] o_add_y2;
  logic             o_add_bit;
  logic             i_add_finish;
  logic [WIDTH-1:0] i_add_x;
  logic [WIDTH-1:0] i_add_y;

  modport master (
    output i_start, i_k, i_px, i_py,
    input  o_busy, o_done, o_rx, o_ry,
    input  o_dbl_start, o_dbl_x, o_dbl_y,
    output i_dbl_finish, i_dbl_x, i_dbl_y,
    input  o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2, o_add_bit,
    output i_add_finish, i_add_x, i_add_y
  );

  modport slave (
    input  i_start, i_k, i_px, i_py,
    output o_busy, o_done, o_rx, o_ry,
    output o_dbl_start, o_dbl_x, o_dbl_y,
    input  i_dbl_finish, i_dbl_x, i_dbl_y,
    output o_add_start, o_add_x1, o_add_y1, o_add_x2, o_add_y2, o_add_bit,
    input  i_add_finish, i_add_x, i_add_y
  );
endinterface

// File: rtl/ecc_scalar_mult_ctrl.sv
// MSB-first double-and-add-always sequencer computing R = k*P.
// It skips the leading zeros of k and loads R = P at the leading one.
// Every remaining bit then issues one doubling and one add request.
// The add request carries the scalar bit as its add/dummy select.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-low reset
//   bus          : slave side of ecc_scalar_mult_ctrl_if
//                  (command/result, doubling unit, add unit)
// The point at infinity is encoded as all-ones on both coordinates.
module ecc_scalar_mult_ctrl #(
  parameter int unsigned WIDTH = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ecc_scalar_mult_ctrl_if.slave bus
);

  localparam int unsigned REM_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_DBL_REQ,
    S_DBL_WAIT,
    S_ADD_REQ,
    S_ADD_WAIT,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] kreg_q, kreg_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
  logic [WIDTH-1:0] px_q, px_d, py_q, py_d;
  logic [WIDTH-1:0] res_x_q, res_x_d, res_y_q, res_y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbl_start_q, dbl_start_d;
  logic             add_start_q, add_start_d;
  logic             p_inf;

  assign p_inf = (px_q == '1) && (py_q == '1);

  // Next state, datapath updates and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    rem_d   = rem_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    px_d    = px_q;
    py_d    = py_q;
    res_x_d = res_x_q;
    res_y_d = res_y_q;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          kreg_d  = bus.i_k;
          px_d    = bus.i_px;
          py_d    = bus.i_py;
          rem_d   = REM_W'(WIDTH);
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if ((kreg_q == '0) || p_inf) begin
          rx_d    = '1;
          ry_d    = '1;
          state_d = S_DONE;
        end else begin
          kreg_d = kreg_q << 1;
          rem_d  = rem_q - REM_W'(1);
          if (kreg_q[WIDTH-1]) begin
            rx_d    = px_q;
            ry_d    = py_q;
            // rem_q == 1 means the leading one was the last bit of k.
            state_d = (rem_q == REM_W'(1)) ? S_DONE : S_DBL_REQ;
          end
        end
      end
      S_DBL_REQ: state_d = S_DBL_WAIT;
      S_DBL_WAIT: begin
        if (bus.i_dbl_finish) begin
          rx_d    = bus.i_dbl_x;
          ry_d    = bus.i_dbl_y;
          state_d = S_ADD_REQ;
        end
      end
      S_ADD_REQ: state_d = S_ADD_WAIT;
      S_ADD_WAIT: begin
        if (bus.i_add_finish) begin
          rx_d    = bus.i_add_x;
          ry_d    = bus.i_add_y;
          kreg_d  = kreg_q << 1;
          rem_d   = rem_q - REM_W'(1);
          state_d = (rem_q == REM_W'(1)) ? S_DONE : S_DBL_REQ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Result is captured on entry to DONE so it appears together with o_done.
    if (state_d == S_DONE) begin
      res_x_d = rx_d;
      res_y_d = ry_d;
    end

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    dbl_start_d = (state_d == S_DBL_REQ);
    add_start_d = (state_d == S_ADD_REQ);
  end

  // State, datapath and output registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      kreg_q      <= '0;
      rem_q       <= '0;
      rx_q        <= '0;
      ry_q        <= '0;
      px_q        <= '0;
      py_q        <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dbl_start_q <= 1'b0;
      add_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kreg_q      <= kreg_d;
      rem_q       <= rem_d;
      rx_q        <= rx_d;
      ry_q        <= ry_d;
      px_q        <= px_d;
      py_q        <= py_d;
      res_x_q     <= res_x_d;
      res_y_q     <= res_y_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dbl_start_q <= dbl_start_d;
      add_start_q <= add_start_d;
    end
  end

  // R and P only change at accepted finishes or at start, so both units see
  // stable operands straight from the accumulator and base-point registers.
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_rx        = res_x_q;
  assign bus.o_ry        = res_y_q;
  assign bus.o_dbl_start = dbl_start_q;
  assign bus.o_dbl_x     = rx_q;
  assign bus.o_dbl_y     = ry_q;
  assign bus.o_add_start = add_start_q;
  assign bus.o_add_x1    = rx_q;
  assign bus.o_add_y1    = ry_q;
  assign bus.o_add_x2    = px_q;
  assign bus.o_add_y2    = py_q;
  assign bus.o_add_bit   = kreg_q[WIDTH-1];

endmodule
